// File: rtl/ct_spsram_init_wrap_pkg.sv
// Shared definitions for the parametrised single-port SRAM wrappers:
// FSM state encoding and read-pipeline depth selectors.
package ct_sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int OUT_REG_DIRECT = 0;
    localparam int OUT_REG_FLOP   = 1;

endpackage

// File: rtl/ct_spsram_init_wrap_if.sv
// Request/response bundle between LSU array control (master) and the SRAM
// init wrapper (slave).
interface ct_spsram_init_wrap_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 54
);
    logic                  init_req;
    logic                  init_busy;
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rdata_vld;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output init_req, req_vld, req_wen, req_addr, req_wdata, req_wmask,
        input  init_busy, req_rdy, rdata_vld, rdata
    );

    modport slave (
        input  init_req, req_vld, req_wen, req_addr, req_wdata, req_wmask,
        output init_busy, req_rdy, rdata_vld, rdata
    );

endinterface

// File: rtl/ct_spsram_init_wrap_macro.sv
// Behavioural single-port SRAM macro: active-low chip/global/bit write
// enables, registered Q that only changes on a read.
module ct_f_spsram_param #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 54
) (
    input  logic                  CLK,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Bits whose WEN is high keep their stored value.
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/ct_spsram_init_wrap.sv
// SRAM wrapper with valid/ready port, bit-masked writes, 1- or 2-cycle read
// pipeline and a hardware sweep that fills every entry with INIT_VALUE.
module ct_spsram_init_wrap
    import ct_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 54,
    parameter int                    OUT_REG    = OUT_REG_DIRECT,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    ct_spsram_init_wrap_if.slave  bus
);

    localparam int                    DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  rd_p1;
    logic                  rd_p2;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] q;
    logic                  rdy;
    logic                  accept;
    logic                  init_write;
    logic [DATA_WIDTH-1:0] mask;
    logic                  cen;
    logic                  gwen;
    logic [DATA_WIDTH-1:0] wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;

    assign init_write = (state == INIT);
    assign rdy        = (state == READY) & ~bus.init_req;
    assign accept     = bus.req_vld & rdy;

    assign bus.req_rdy   = rdy;
    assign bus.init_busy = init_write;

    // Sweep writes init_cnt every INIT cycle; init_req mid-sweep is ignored.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == LAST_ADDR) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (bus.init_req) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    assign mask  = init_write ? {DATA_WIDTH{1'b1}} : bus.req_wmask;
    assign addr  = init_write ? init_cnt : bus.req_addr;
    assign wdata = init_write ? INIT_VALUE : bus.req_wdata;
    assign cen   = ~(accept | init_write);
    assign gwen  = ~(init_write | (accept & bus.req_wen));
    assign wen   = ~mask;

    ct_f_spsram_param #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_macro (
        .CLK  (forever_cpuclk),
        .CEN  (cen),
        .GWEN (gwen),
        .WEN  (wen),
        .A    (addr),
        .D    (wdata),
        .Q    (q)
    );

    // rdata_q keeps the last read word so rdata holds between reads.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_p1   <= 1'b0;
            rd_p2   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rd_p1 <= accept & ~bus.req_wen;
            rd_p2 <= (OUT_REG == OUT_REG_FLOP) & rd_p1;
            if (rd_p1) begin
                rdata_q <= q;
            end
        end
    end

    assign bus.rdata_vld = (OUT_REG == OUT_REG_FLOP) ? rd_p2 : rd_p1;
    assign bus.rdata     = ((OUT_REG == OUT_REG_FLOP) || !rd_p1) ? rdata_q : q;

endmodule

// File: doc/ct_spsram_init_wrap.md
# ct_spsram_init_wrap

Parametrised single-port SRAM wrapper for LSU/cache arrays, generalising the fixed 512x54 wrappers. Adds a valid/ready request port, a configurable read pipeline (1 or 2 cycles), active-high bit-mask writes, and a hardware init sweep that fills every entry with `INIT_VALUE` after reset or on request. It sits between LSU tag/data control logic and the FPGA/foundry macro, so arrays never need software clearing.

## Interface
- `ADDR_WIDTH`, 9: address bits; `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 54: data word width.
- `OUT_REG`, 0: 0 = read data one cycle after accept; 1 = extra output flop, two cycles.
- `INIT_VALUE`, 0: `DATA_WIDTH`-bit word written to every entry during init.
- `forever_cpuclk`  in  1  sole clock.
- `cpurst_b`  in  1  reset, asynchronous, active-low.
- `init_req`  in  1  single-cycle pulse that starts a re-init sweep.
- `init_busy`  out  1  high while the sweep runs.
- `req_vld`  in  1  access request.
- `req_rdy`  out  1  wrapper accepts the request this cycle.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_WIDTH`  entry index.
- `req_wdata`  in  `DATA_WIDTH`  write data.
- `req_wmask`  in  `DATA_WIDTH`  per-bit write enable, 1 = write bit.
- `rdata_vld`  out  1  single-cycle pulse marking valid `rdata`.
- `rdata`  out  `DATA_WIDTH`  read data; holds its value between reads.

## Operation
- FSM states: INIT, READY.
  - Reset puts the FSM in INIT with `init_cnt = 0`.
  - INIT → READY after the write to `DEPTH-1`.
  - READY → INIT on `init_req`, with `init_cnt` cleared.
- In INIT, each cycle writes `INIT_VALUE` with the full mask to `init_cnt`, then increments `init_cnt`. The sweep takes exactly `DEPTH` cycles.
- `init_req` while in INIT is ignored; the sweep does not restart.
- `req_rdy = (state == READY) & ~init_req`. A request is accepted when `req_vld & req_rdy`. When `init_req` and `req_vld` arrive in the same cycle, init wins and the request is not accepted.
- Macro drive (active-low):
  - `CEN = ~(accept | init_write)`
  - `GWEN = ~(init_write | (accept & req_wen))`
  - `WEN = ~mask`, where `mask` is all ones during init and `req_wmask` otherwise.
- Masked write: bits with mask 0 keep their old value. A write with an all-zero mask is accepted and leaves the entry unchanged.
- Read pipeline: `rd_p1` flags an accepted read. With `OUT_REG = 1`, `rd_p2` is added, which re-flops macro Q into `rdata`.
- Reads accepted before an `init_req` still complete: `rdata_vld` fires on schedule while INIT runs, and the data is the pre-init contents.
- Writes return nothing; `rdata_vld` never pulses for a write.

## Timing
- Reset values: `init_busy = 1`, `req_rdy = 0`, `rdata_vld = 0`, `rdata = 0`, `init_cnt = 0`, pipeline flags 0.
- `init_busy` falls, and `req_rdy` rises, on the first edge after the `DEPTH`-th init write. Deassertion of `cpurst_b` to first `req_rdy` takes `DEPTH` cycles.
- `init_req` sampled at edge N: `init_busy` is high from N+1, and the first init write is at N+1.
- Read accepted at edge N:
  - `OUT_REG = 0`: `rdata`/`rdata_vld` valid after edge N+1.
  - `OUT_REG = 1`: valid after edge N+2.
- Back-to-back reads sustain one per cycle.
- Write accepted at N, then a read of the same address at N+1: the read returns the new data (macro write completes at N).
- Reset asserted mid-sweep or mid-read: all state clears asynchronously, in-flight `rdata_vld` is dropped, and the sweep restarts from 0 after deassertion.
- `init_cnt` is `ADDR_WIDTH` bits wide. The sweep ends on `init_cnt == DEPTH-1`, with no wrap to a second pass.

## Structure
- Shared package `ct_sram_pkg`: FSM state encoding (INIT = 1'b0, READY = 1'b1) and the `OUT_REG` mode constants.
- Sub-module: `ct_f_spsram_param`, a behavioural macro with `ADDR_WIDTH`/`DATA_WIDTH` parameters and active-low `CEN`/`GWEN`/`WEN`, 1-cycle Q. The wrapper contains only the FSM, address mux, mask inversion and read pipeline.

## Test plan
- **Power-on sweep:** `ADDR_WIDTH = 4`, `INIT_VALUE = 54'h2A` → `req_rdy` low for 16 cycles after reset release. Reads of addresses 0 and 15 then return `54'h2A`.
- **Masked write:** write `54'h3FFFFFFFFFFFFF` to address 3 with mask `54'hFF`, then read address 3 → `rdata = 54'h2A & ~54'hFF | 54'hFF = 54'hFF`, with `rdata_vld` one cycle after accept (`OUT_REG = 0`) or two cycles (`OUT_REG = 1`).
- **Streaming reads:** back-to-back reads of addresses 0..15 → 16 consecutive `rdata_vld` pulses with the data in address order.
- **Init with a read in flight:** `init_req` in the cycle after a read is accepted → that read still returns the old value. `init_busy` is high for 16 cycles, and all entries read `INIT_VALUE` afterwards.
- **Same-cycle conflict:** `init_req` together with `req_vld` (write to address 5, data 0x1) → no accept. After the sweep, address 5 reads `INIT_VALUE`.
- **Reset mid-sweep:** assert `cpurst_b = 0` at sweep cycle 7 → outputs return to reset values immediately. After release, the full 16-cycle sweep reruns.
